// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: global freeze for MUL/DIV and data-memory waits,
// plus local load-use bubble and taken-branch flush when the pipe is running.
module hazard_stall_controller #(
  parameter int MD_LATENCY = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] ID_RS1_i,
  input  logic [4:0] ID_RS2_i,
  input  logic       ID_Branch_taken_i,
  input  logic       EX_MemRead_i,
  input  logic [4:0] EX_Rd_i,
  input  logic       EX_MulDiv_i,
  input  logic       MEM_Access_i,
  input  logic       mem_ready_i,
  output logic       PC_Write_o,
  output logic       IFID_Write_o,
  output logic       IFID_Flush_o,
  output logic       IDEX_Bubble_o,
  output logic       Pipe_Stall_o,
  output logic       MD_start_o,
  output logic       MD_busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MD_RUN   = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // The start cycle already counts as one EX cycle and the exit cycle another.
  localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;
  logic       md_done_q;
  logic       md_done_next;

  logic       mem_block;
  logic       load_use;
  logic       stall;
  logic       md_start;

  assign mem_block = MEM_Access_i && !mem_ready_i;
  assign load_use  = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
                     ((EX_Rd_i == ID_RS1_i) || (EX_Rd_i == ID_RS2_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      md_done_q <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      md_done_q <= md_done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    md_done_next = md_done_q;
    stall        = 1'b0;
    md_start     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Memory wait takes precedence; MUL/DIV starts once memory has completed.
        if (mem_block) begin
          stall      = 1'b1;
          state_next = MEM_WAIT;
        end else if (EX_MulDiv_i) begin
          stall      = 1'b1;
          md_start   = 1'b1;
          cnt_next   = MD_INIT;
          state_next = MD_RUN;
        end
      end
      MD_RUN: begin
        if (cnt_reg != 4'd0) begin
          stall    = 1'b1;
          cnt_next = cnt_reg - 4'd1;
        end else if (mem_block) begin
          // Result is ready; remember it so the memory wait does not restart the unit.
          stall        = 1'b1;
          md_done_next = 1'b1;
          state_next   = MEM_WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready_i) begin
          stall = 1'b1;
        end else if (EX_MulDiv_i && !md_done_q) begin
          stall      = 1'b1;
          md_start   = 1'b1;
          cnt_next   = MD_INIT;
          state_next = MD_RUN;
        end else begin
          md_done_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        cnt_next     = 4'd0;
        md_done_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    PC_Write_o    = 1'b1;
    IFID_Write_o  = 1'b1;
    IFID_Flush_o  = 1'b0;
    IDEX_Bubble_o = 1'b0;
    Pipe_Stall_o  = 1'b0;
    MD_start_o    = 1'b0;
    MD_busy_o     = 1'b0;
    if (rst_i) begin
      MD_start_o = md_start;
      MD_busy_o  = (state_reg == MD_RUN);
      if (stall) begin
        Pipe_Stall_o = 1'b1;
        PC_Write_o   = 1'b0;
        IFID_Write_o = 1'b0;
      end else if (load_use) begin
        // Bubble wins over a taken branch; the flush returns once the hazard clears.
        PC_Write_o    = 1'b0;
        IFID_Write_o  = 1'b0;
        IDEX_Bubble_o = 1'b1;
      end else begin
        IFID_Flush_o = ID_Branch_taken_i;
      end
    end
  end

endmodule
